// File: rtl/dbg_uart_loader.sv
// Host-driven debug loader: UART byte frames become masked debug-memory writes while the CPU is held.
// Optional macro DBG_UART_LOADER_CKSUM_EN adds a trailing XOR checksum byte to write frames.
module dbg_uart_loader #(
  parameter int unsigned WR_CYCLES   = 2,
  parameter int unsigned TIMEOUT     = 100000,
  parameter bit          BOOT_HALTED = 1'b1,
  parameter logic [7:0]  ACK_BYTE    = 8'h06,
  parameter logic [7:0]  NAK_BYTE    = 8'h15
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        dbg_mem_op,
  output logic [3:0]  dbg_wren,
  output logic [31:0] dbg_adr,
  output logic [31:0] dbg_do,
  output logic        cpu_n_reset,
  output logic        err_overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_CKSUM, S_WRITE, S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] addr_buf_q, addr_buf_d;
  logic [31:0] data_buf_q, data_buf_d;
  logic [31:0] tmo_q, tmo_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        mem_op_q, mem_op_d;
  logic [3:0]  wren_q, wren_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] do_q, do_d;
  logic        cpu_n_reset_q, cpu_n_reset_d;
  logic        err_overrun_q, err_overrun_d;
`ifdef DBG_UART_LOADER_CKSUM_EN
  logic [7:0]  cks_q, cks_d;
`endif

  logic        resp_en;
  logic [7:0]  resp_byte;
  logic        frame_done;
  logic        frame_ok;
  logic [31:0] frame_data;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    mask_d        = mask_q;
    addr_buf_d    = addr_buf_q;
    data_buf_d    = data_buf_q;
    tmo_d         = tmo_q;
    wcnt_d        = wcnt_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;
    mem_op_d      = mem_op_q;
    wren_d        = wren_q;
    adr_d         = adr_q;
    do_d          = do_q;
    cpu_n_reset_d = cpu_n_reset_q;
    err_overrun_d = err_overrun_q;
`ifdef DBG_UART_LOADER_CKSUM_EN
    cks_d         = cks_q;
`endif
    resp_en       = 1'b0;
    resp_byte     = NAK_BYTE;
    frame_done    = 1'b0;
    frame_ok      = 1'b0;
    frame_data    = data_buf_q;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data[7:4] == 4'hA && rx_data[3:0] != 4'h0) begin
            mask_d  = rx_data[3:0];
            idx_d   = 2'd0;
            tmo_d   = 32'd0;
            state_d = S_ADDR;
`ifdef DBG_UART_LOADER_CKSUM_EN
            cks_d   = rx_data;
`endif
          end else if (rx_data == 8'hC0) begin
            cpu_n_reset_d = 1'b0;
            err_overrun_d = 1'b0;
            resp_en       = 1'b1;
            resp_byte     = ACK_BYTE;
          end else if (rx_data == 8'hC1) begin
            cpu_n_reset_d = 1'b1;
            resp_en       = 1'b1;
            resp_byte     = ACK_BYTE;
          end else begin
            resp_en       = 1'b1;
          end
        end
      end
      S_ADDR, S_DATA, S_CKSUM: begin
        if (rx_valid) begin
          tmo_d = 32'd0;
          idx_d = idx_q + 2'd1;
`ifdef DBG_UART_LOADER_CKSUM_EN
          cks_d = cks_q ^ rx_data;
`endif
          if (state_q == S_ADDR) begin
            addr_buf_d[{idx_q, 3'b000} +: 8] = rx_data;
            if (idx_q == 2'd3) state_d = S_DATA;
          end else if (state_q == S_DATA) begin
            data_buf_d[{idx_q, 3'b000} +: 8] = rx_data;
            if (idx_q == 2'd3) begin
`ifdef DBG_UART_LOADER_CKSUM_EN
              state_d = S_CKSUM;
`else
              frame_done = 1'b1;
              frame_ok   = 1'b1;
              frame_data = {rx_data, data_buf_q[23:0]};
`endif
            end
          end else begin
`ifdef DBG_UART_LOADER_CKSUM_EN
            frame_done = 1'b1;
            frame_ok   = (rx_data == cks_q);
            frame_data = data_buf_q;
`else
            state_d = S_IDLE;
`endif
          end
        end else if (tmo_q == TIMEOUT - 1) begin
          // Stale partial frame: drop silently, outputs untouched.
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      S_WRITE: begin
        if (rx_valid) err_overrun_d = 1'b1;
        // Address/data/mask were loaded on entry; raise the strobe one cycle later.
        if (!mem_op_q) begin
          mem_op_d = 1'b1;
          wcnt_d   = 8'd1;
        end else if (wcnt_q == 8'(WR_CYCLES)) begin
          mem_op_d  = 1'b0;
          wren_d    = 4'h0;
          resp_en   = 1'b1;
          resp_byte = ACK_BYTE;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      S_RESP: begin
        if (rx_valid) err_overrun_d = 1'b1;
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (frame_done) begin
      if (frame_ok && !cpu_n_reset_q) begin
        adr_d   = addr_buf_q;
        do_d    = frame_data;
        wren_d  = mask_q;
        state_d = S_WRITE;
      end else begin
        resp_en = 1'b1;
      end
    end

    if (resp_en) begin
      tx_data_d  = resp_byte;
      tx_valid_d = 1'b1;
      state_d    = S_RESP;
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q       <= S_IDLE;
      idx_q         <= 2'd0;
      mask_q        <= 4'h0;
      addr_buf_q    <= 32'd0;
      data_buf_q    <= 32'd0;
      tmo_q         <= 32'd0;
      wcnt_q        <= 8'd0;
      tx_data_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
      mem_op_q      <= 1'b0;
      wren_q        <= 4'h0;
      adr_q         <= 32'd0;
      do_q          <= 32'd0;
      cpu_n_reset_q <= ~BOOT_HALTED;
      err_overrun_q <= 1'b0;
`ifdef DBG_UART_LOADER_CKSUM_EN
      cks_q         <= 8'h00;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      mask_q        <= mask_d;
      addr_buf_q    <= addr_buf_d;
      data_buf_q    <= data_buf_d;
      tmo_q         <= tmo_d;
      wcnt_q        <= wcnt_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      mem_op_q      <= mem_op_d;
      wren_q        <= wren_d;
      adr_q         <= adr_d;
      do_q          <= do_d;
      cpu_n_reset_q <= cpu_n_reset_d;
      err_overrun_q <= err_overrun_d;
`ifdef DBG_UART_LOADER_CKSUM_EN
      cks_q         <= cks_d;
`endif
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign dbg_mem_op  = mem_op_q;
  assign dbg_wren    = wren_q;
  assign dbg_adr     = adr_q;
  assign dbg_do      = do_q;
  assign cpu_n_reset = cpu_n_reset_q;
  assign err_overrun = err_overrun_q;

endmodule
